wb_mem_bridge: RTL

Wishbone-to-byte-memory bridge: accepts 32-bit big-endian Wishbone classic single accesses from the OpenRISC data/instruction bus and sequences them into byte-wide accesses on the 16 KB memory port (14-bit address, 8-bit data, synchronous read, 8 banks of 2 KB selected by address bits 13:11). It is the initiator side of the byte memory interface and sits between the bus arbiter and the on-chip memory.

---
 rtl/mem_if_pkg.sv | 54 +++++
 rtl/wb_mem_lane_seq.sv | 39 +++
 rtl/wb_mem_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the Wishbone-to-byte-memory bridge: FSM states,
// memory geometry and the big-endian lane/offset mapping helpers.
package mem_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_ERR
    } state_e;

    localparam int unsigned MEM_ADR_W    = 14;
    localparam int unsigned MEM_BANK_MSB = 13;
    localparam int unsigned MEM_BANK_LSB = 11;
    localparam int unsigned LANES        = 4;

    // Byte offset 0 is sel[3] and data[31:24]; offset 3 is sel[0] and data[7:0].
    function automatic logic [3:0] lane_sel(input logic [1:0] off);
        return 4'b1000 >> off;
    endfunction

    function automatic logic [1:0] first_lane(input logic [3:0] mask);
        casez (mask)
            4'b1???: return 2'd0;
            4'b01??: return 2'd1;
            4'b001?: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
        case (off)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] off,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (off)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/wb_mem_lane_seq.sv
// Lane sequencer: holds the not-yet-served byte lanes of a transfer and
// presents them in ascending byte-offset order.
module wb_mem_lane_seq
    import mem_if_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] mask_i,
    input  logic       adv_i,
    output logic [1:0] off_o,
    output logic       last_o
);

    logic [3:0] rem_q, rem_d;
    logic [3:0] src;

    // Loading and advancing in the same cycle consumes the first lane of the new mask.
    always_comb begin
        src    = load_i ? mask_i : rem_q;
        off_o  = first_lane(src);
        last_o = (src != 4'd0) && ((src & (src - 4'd1)) == 4'd0);
        rem_d  = rem_q;
        if (adv_i) begin
            rem_d = src & ~lane_sel(off_o);
        end else if (load_i) begin
            rem_d = src;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/wb_mem_bridge.sv
// Wishbone classic 32-bit big-endian slave that sequences each access into
// byte-wide cycles on a 16 KB synchronous-read memory port.
module wb_mem_bridge
    import mem_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic [MEM_ADR_W-1:0] mem_adr,
    output logic [7:0]           mem_dat_o,
    input  logic [7:0]           mem_dat_i,
    output logic                 mem_we,
    output logic                 mem_en
);

    state_e                 state_q, state_d;
    logic [MEM_ADR_W-1:2]   adr_q, adr_d;
    logic [31:0]            wdat_q, wdat_d;
    logic [MEM_ADR_W-1:0]   mem_adr_q, mem_adr_d;
    logic [7:0]             mem_dat_q, mem_dat_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_en_q, mem_en_d;
    logic [31:0]            rdat_q, rdat_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   last_q, last_d;
    logic                   drain_q, drain_d;
    logic                   rd_v_q, rd_v_d;
    logic [1:0]             rd_off_q, rd_off_d;

    logic                   seq_load, seq_adv, seq_last;
    logic [1:0]             seq_off;
    logic                   hit;
    logic                   unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];
    assign hit        = (wb_adr_i[31:MEM_ADR_W] == BASE_ADR[31:MEM_ADR_W]);

    wb_mem_lane_seq u_lane_seq (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (seq_load),
        .mask_i (wb_sel_i),
        .adv_i  (seq_adv),
        .off_o  (seq_off),
        .last_o (seq_last)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        mem_adr_d = mem_adr_q;
        mem_dat_d = mem_dat_q;
        mem_we_d  = mem_we_q;
        mem_en_d  = mem_en_q;
        rdat_d    = rdat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        last_d    = last_q;
        drain_d   = drain_q;
        rd_v_d    = rd_v_q;
        rd_off_d  = rd_off_q;
        seq_load  = 1'b0;
        seq_adv   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d  = wb_adr_i[MEM_ADR_W-1:2];
                    wdat_d = wb_dat_i;
                    if (!hit || (wb_sel_i == 4'd0)) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        // The first lane goes out on the same edge the request is sampled.
                        seq_load  = 1'b1;
                        seq_adv   = 1'b1;
                        mem_en_d  = 1'b1;
                        mem_we_d  = wb_we_i;
                        mem_adr_d = {wb_adr_i[MEM_ADR_W-1:2], seq_off};
                        last_d    = seq_last;
                        drain_d   = 1'b0;
                        rd_v_d    = 1'b0;
                        if (wb_we_i) begin
                            mem_dat_d = lane_byte(wb_dat_i, seq_off);
                            state_d   = ST_WRITE;
                        end else begin
                            rdat_d  = '0;
                            state_d = ST_READ;
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (!wb_cyc_i) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (last_q) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = ST_ACK;
                end else begin
                    seq_adv   = 1'b1;
                    mem_adr_d = {adr_q, seq_off};
                    mem_dat_d = lane_byte(wdat_q, seq_off);
                    last_d    = seq_last;
                end
            end

            ST_READ: begin
                if (!wb_cyc_i) begin
                    mem_en_d = 1'b0;
                    drain_d  = 1'b0;
                    rd_v_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    // rd_v/rd_off track the lane whose byte is on mem_dat_i this cycle.
                    if (rd_v_q) begin
                        rdat_d = put_lane(rdat_q, rd_off_q, mem_dat_i);
                    end
                    rd_v_d   = !drain_q;
                    rd_off_d = mem_adr_q[1:0];
                    if (drain_q) begin
                        mem_en_d = 1'b0;
                        drain_d  = 1'b0;
                        ack_d    = 1'b1;
                        state_d  = ST_ACK;
                    end else if (last_q) begin
                        drain_d = 1'b1;
                    end else begin
                        seq_adv   = 1'b1;
                        mem_adr_d = {adr_q, seq_off};
                        last_d    = seq_last;
                    end
                end
            end

            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
            mem_we_q  <= 1'b0;
            mem_en_q  <= 1'b0;
            rdat_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= 1'b0;
            drain_q   <= 1'b0;
            rd_v_q    <= 1'b0;
            rd_off_q  <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            mem_adr_q <= mem_adr_d;
            mem_dat_q <= mem_dat_d;
            mem_we_q  <= mem_we_d;
            mem_en_q  <= mem_en_d;
            rdat_q    <= rdat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            last_q    <= last_d;
            drain_q   <= drain_d;
            rd_v_q    <= rd_v_d;
            rd_off_q  <= rd_off_d;
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign mem_adr   = mem_adr_q;
    assign mem_dat_o = mem_dat_q;
    assign mem_we    = mem_we_q;
    assign mem_en    = mem_en_q;

endmodule
